// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Stimulus-and-capture wrapper for an external N_IN-input combinational
//   expression stage. On start it steps abc_o through every input
//   combination, waits SETTLE cycles after each new vector, samples s_in_i,
//   and builds the full truth table in table_o (table_o[k] = s_in_i while
//   abc_o == k) together with its population count in ones_o.
//
// Parameters
//   N_IN    number of expression inputs (1..4)
//   SETTLE  wait cycles after each new vector before sampling (1..15)
//   GOLDEN  expected truth table, used only with the golden check build
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_i     sweep request, sampled only while idle
//   abc_o       registered vector to the expression stage (MSB = a)
//   s_in_i      expression stage output
//   busy_o      high while a sweep is in progress (WAIT and SAMPLE)
//   done_o      one-cycle pulse when the table is final
//   table_o     captured truth table, 2**N_IN bits
//   ones_o      number of 1s in table_o
//   mismatch_o  final table differs from GOLDEN (golden check build only)
//
// Build option
//   TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN  enables the GOLDEN comparison;
//   otherwise mismatch_o is tied low and GOLDEN is unused.

module truth_table_sweeper #(
    parameter int unsigned        N_IN   = 3,
    parameter int unsigned        SETTLE = 1,
    parameter logic [2**N_IN-1:0] GOLDEN = 8'h70
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic [N_IN-1:0]      abc_o,
    input  logic                 s_in_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2**N_IN-1:0]   table_o,
    output logic [N_IN:0]        ones_o,
    output logic                 mismatch_o
);

    localparam int unsigned TW       = 2**N_IN;
    localparam logic [3:0]  CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   abc_q,   abc_d;
    logic [TW-1:0]     table_q, table_d;
    logic [N_IN:0]     ones_q,  ones_d;
    logic [3:0]        cnt_q,   cnt_d;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    logic              mismatch_q, mismatch_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            abc_q      <= '0;
            table_q    <= '0;
            ones_q     <= '0;
            cnt_q      <= '0;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            abc_q      <= abc_d;
            table_q    <= table_d;
            ones_q     <= ones_d;
            cnt_q      <= cnt_d;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        abc_d      = abc_q;
        table_d    = table_q;
        ones_d     = ones_q;
        cnt_d      = cnt_q;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
        mismatch_d = mismatch_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    abc_d      = '0;
                    table_d    = '0;
                    ones_d     = '0;
                    cnt_d      = CNT_INIT;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                table_d[abc_q] = s_in_i;
                ones_d         = ones_q + {{N_IN{1'b0}}, s_in_i};
                if (&abc_q) begin
                    state_d = S_DONE;
`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
                    // table_d already carries the last sampled bit, so the
                    // compare result is ready alongside done.
                    mismatch_d = (table_d != GOLDEN);
`endif
                end else begin
                    abc_d   = abc_q + N_IN'(1);
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                abc_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o = (state_q == S_WAIT) || (state_q == S_SAMPLE);
        done_o = (state_q == S_DONE);
    end

    assign abc_o   = abc_q;
    assign table_o = table_q;
    assign ones_o  = ones_q;

`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed testbench for truth_table_sweeper.
//   dut_a: N_IN=3, SETTLE=1, s_in selected by `mode`
//          (0 = direct expression, 1 = tied high, 2 = expression delayed 2 cycles)
//   dut_b: N_IN=3, SETTLE=3, s_in = expression delayed 2 cycles
// Expression stage: s = a & ~(b & c).

module tb_truth_table_sweeper;

`ifdef TRUTH_TABLE_SWEEPER_GOLDEN_CHECK_EN
    localparam logic GC = 1'b1;
`else
    localparam logic GC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, s_in_a, busy_a, done_a, mis_a;
    logic [2:0] abc_a;
    logic [7:0] table_a;
    logic [3:0] ones_a;
    logic       start_b, s_in_b, busy_b, done_b, mis_b;
    logic [2:0] abc_b;
    logic [7:0] table_b;
    logic [3:0] ones_b;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;

    logic d1a, d2a, d1b, d2b;

    function automatic logic expr3(input logic [2:0] v);
        return v[2] & ~(v[1] & v[0]);
    endfunction

    always @(posedge clk) begin
        d1a <= expr3(abc_a);
        d2a <= d1a;
        d1b <= expr3(abc_b);
        d2b <= d1b;
    end

    assign s_in_a = (mode == 0) ? expr3(abc_a) : (mode == 1) ? 1'b1 : d2a;
    assign s_in_b = d2b;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .GOLDEN(8'h70)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abc_o(abc_a),
        .s_in_i(s_in_a), .busy_o(busy_a), .done_o(done_a), .table_o(table_a),
        .ones_o(ones_a), .mismatch_o(mis_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3), .GOLDEN(8'h70)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abc_o(abc_b),
        .s_in_i(s_in_b), .busy_o(busy_b), .done_o(done_b), .table_o(table_b),
        .ones_o(ones_b), .mismatch_o(mis_b)
    );

    // Runs one dut_a sweep. Cycle c is the cycle after the c-th edge counted
    // from the accept edge (c=0); lat is the c at which done is seen.
    task automatic sweep_a(input int pulse_at, input bit hold,
                           output int lat, output int abc_bad, output int busy_cnt);
        int c;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        c = 0; lat = -1; abc_bad = 0; busy_cnt = 0;
        while (c < 200) begin
            @(negedge clk);
            start_a = hold || (c == pulse_at);
            if (done_a === 1'b1) begin
                lat = c;
                break;
            end
            if (abc_a !== 3'(c / 2)) abc_bad++;
            if (busy_a === 1'b1) busy_cnt++;
            c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({abc_a, busy_a, done_a, table_a, ones_a, mis_a} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_a: abc=%0h busy=%b done=%b table=%h ones=%0d mis=%b, want all 0",
                     abc_a, busy_a, done_a, table_a, ones_a, mis_a);
        end
        n_cmp++;
        if ({abc_b, busy_b, done_b, table_b, ones_b, mis_b} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_b: abc=%0h busy=%b done=%b table=%h ones=%0d mis=%b, want all 0",
                     abc_b, busy_b, done_b, table_b, ones_b, mis_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_expr_sweep();
        int lat, abc_bad, busy_cnt;
        mode = 0;
        sweep_a(-1, 1'b0, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (lat != 16) begin n_bad++; $display("FAIL expr_latency: got %0d want 16", lat); end
        n_cmp++;
        if (abc_bad != 0) begin n_bad++; $display("FAIL expr_abc_seq: %0d bad cycles want 0", abc_bad); end
        n_cmp++;
        if (busy_cnt != 16) begin n_bad++; $display("FAIL expr_busy_cycles: got %0d want 16", busy_cnt); end
        n_cmp++;
        if (busy_a !== 1'b0) begin n_bad++; $display("FAIL expr_busy_in_done: got %b want 0", busy_a); end
        n_cmp++;
        if (table_a !== 8'h70) begin n_bad++; $display("FAIL expr_table: got %h want 70", table_a); end
        n_cmp++;
        if (ones_a !== 4'd3) begin n_bad++; $display("FAIL expr_ones: got %0d want 3", ones_a); end
        @(negedge clk);
        n_cmp++;
        if (mis_a !== 1'b0) begin n_bad++; $display("FAIL expr_mismatch: got %b want 0", mis_a); end
        n_cmp++;
        if ({abc_a, done_a, busy_a} !== 5'd0) begin
            n_bad++;
            $display("FAIL expr_after_done: abc=%0h done=%b busy=%b want 0 0 0", abc_a, done_a, busy_a);
        end
    endtask

    task automatic test_idle_hold();
        int bad;
        bad = 0;
        start_a = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (table_a !== 8'h70 || ones_a !== 4'd3 || mis_a !== 1'b0 ||
                abc_a !== 3'd0 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL idle_hold: %0d cycles changed (table=%h ones=%0d mis=%b abc=%0h), want 0",
                     bad, table_a, ones_a, mis_a, abc_a);
        end
    endtask

    task automatic test_all_ones();
        int lat, abc_bad, busy_cnt;
        mode = 1;
        sweep_a(-1, 1'b0, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (table_a !== 8'hFF) begin n_bad++; $display("FAIL ones_table: got %h want ff", table_a); end
        n_cmp++;
        if (ones_a !== 4'd8) begin n_bad++; $display("FAIL ones_count: got %0d want 8", ones_a); end
        @(negedge clk);
        n_cmp++;
        if (mis_a !== GC) begin n_bad++; $display("FAIL ones_mismatch: got %b want %b", mis_a, GC); end
    endtask

    task automatic test_ignored_start();
        int lat, abc_bad, busy_cnt, extra;
        mode = 0;
        sweep_a(5, 1'b0, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (lat != 16) begin n_bad++; $display("FAIL ign_latency: got %0d want 16", lat); end
        n_cmp++;
        if (abc_bad != 0) begin n_bad++; $display("FAIL ign_abc_seq: %0d bad cycles want 0", abc_bad); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL ign_extra_activity: got %0d cycles want 0", extra); end
        n_cmp++;
        if (mis_a !== 1'b0) begin n_bad++; $display("FAIL ign_mismatch_cleared: got %b want 0", mis_a); end
    endtask

    task automatic test_back_to_back();
        int lat, abc_bad, busy_cnt, c;
        mode = 0;
        sweep_a(-1, 1'b1, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (lat != 16) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 16", lat); end
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || table_a !== 8'h70) begin
            n_bad++;
            $display("FAIL b2b_idle_cycle: busy=%b table=%h want 0 70", busy_a, table_a);
        end
        @(negedge clk);
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1 || table_a !== 8'h00 || ones_a !== 4'd0 || abc_a !== 3'd0) begin
            n_bad++;
            $display("FAIL b2b_restart: busy=%b table=%h ones=%0d abc=%0h want 1 00 0 0",
                     busy_a, table_a, ones_a, abc_a);
        end
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (done_a === 1'b1) break;
        end
        n_cmp++;
        if (c != 16) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 16", c); end
        n_cmp++;
        if (table_a !== 8'h70) begin n_bad++; $display("FAIL b2b_table2: got %h want 70", table_a); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, abc_bad, busy_cnt, c;
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        c = 0;
        while (c < 6) begin
            @(negedge clk);
            start_a = 1'b0;
            c++;
        end
        @(negedge clk);
        n_cmp++;
        if (abc_a !== 3'd3 || busy_a !== 1'b1 || table_a !== 8'h07) begin
            n_bad++;
            $display("FAIL arst_pre: abc=%0h busy=%b table=%h want 3 1 07", abc_a, busy_a, table_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({abc_a, busy_a, done_a, table_a, ones_a, mis_a} !== 18'd0) begin
            n_bad++;
            $display("FAIL arst_clear: abc=%0h busy=%b done=%b table=%h ones=%0d mis=%b want all 0",
                     abc_a, busy_a, done_a, table_a, ones_a, mis_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        repeat (2) @(negedge clk);
        sweep_a(-1, 1'b0, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (lat != 16 || abc_bad != 0 || table_a !== 8'h70) begin
            n_bad++;
            $display("FAIL arst_resweep: lat=%0d abc_bad=%0d table=%h want 16 0 70", lat, abc_bad, table_a);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_settle3();
        int c;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (done_b === 1'b1) begin
                c = i;
                break;
            end
        end
        n_cmp++;
        if (c != 32) begin n_bad++; $display("FAIL s3_latency: got %0d want 32", c); end
        n_cmp++;
        if (table_b !== 8'h70) begin n_bad++; $display("FAIL s3_table: got %h want 70", table_b); end
        n_cmp++;
        if (ones_b !== 4'd3) begin n_bad++; $display("FAIL s3_ones: got %0d want 3", ones_b); end
        @(negedge clk);
        n_cmp++;
        if (mis_b !== 1'b0) begin n_bad++; $display("FAIL s3_mismatch: got %b want 0", mis_b); end
    endtask

    // SETTLE=1 with a 2-cycle delayed expression: each entry k captures the
    // value for k-1 (entry 0 sees the idle vector 0), giving 8'hE0.
    task automatic test_stale();
        int lat, abc_bad, busy_cnt;
        mode = 2;
        repeat (3) @(negedge clk);
        sweep_a(-1, 1'b0, lat, abc_bad, busy_cnt);
        n_cmp++;
        if (table_a !== 8'hE0) begin n_bad++; $display("FAIL stale_table: got %h want e0", table_a); end
        n_cmp++;
        if (ones_a !== 4'd3) begin n_bad++; $display("FAIL stale_ones: got %0d want 3", ones_a); end
        @(negedge clk);
        n_cmp++;
        if (mis_a !== GC) begin n_bad++; $display("FAIL stale_mismatch: got %b want %b", mis_a, GC); end
    endtask

    initial begin
        test_reset();
        test_expr_sweep();
        test_idle_hold();
        test_all_ones();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        test_settle3();
        test_stale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
